step_display_ctrl: RTL

//  Board-side companion to the pipelined CPU top. Turns a raw push-button into a

---
 rtl/step_display_ctrl_pkg.sv | 47 ++++
 rtl/step_display_ctrl_seg7_decoder.sv | 33 +++
 rtl/step_display_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/step_display_ctrl_pkg.sv
// Shared types and constants for the step/display board controller.
// Debounce FSM states, active-low segment patterns and small helpers.
package step_display_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low enable for one digit; bit 0 is the rightmost digit.
  function automatic logic [3:0] digit_anode(
    input logic [1:0] idx
  );
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [15:0] pick_half(
    input logic [31:0] word,
    input logic        upper
  );
    return upper ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/step_display_ctrl_seg7_decoder.sv
// Combinational hex digit to active-low 7-segment pattern.
// Ports: hex (4-bit digit in), seg ({g,f,e,d,c,b,a} out, active-low).
module seg7_decoder
  import step_display_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/step_display_ctrl.sv
// Debounced single-step pulse plus 4-digit hex scan of PC / register.
// Ports: clk, reset (sync, active-high), step_btn, view_sel, half_sel,
//   pc_in, reg_in -> step_pulse, anode (active-low), seg, dp (active-low).
// Both parameters must be at least 2.
module step_display_ctrl
  import step_display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        view_sel,
  input  logic        half_sel,
  input  logic [31:0] pc_in,
  input  logic [31:0] reg_in,
  output logic        step_pulse,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DB_W =
    ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RF_W =
    ($clog2(REFRESH_CYCLES) > 0) ? $clog2(REFRESH_CYCLES) : 1;

  // The state change lands on the edge where db_cnt steps to its last
  // value, so the synced level must be seen for DEBOUNCE_CYCLES edges.
  localparam logic [DB_W-1:0] DB_PRE_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [RF_W-1:0] RF_LAST     = RF_W'(REFRESH_CYCLES - 1);

  logic            sync_a;
  logic            btn_s;
  db_state_t       state;
  logic [DB_W-1:0] db_cnt;
  logic [RF_W-1:0] ref_cnt;
  logic [1:0]      digit_idx;
  logic [15:0]     snapshot;
  logic [3:0]      nibble;
  logic [6:0]      seg_next;

  // Cleared on reset so a held button must re-qualify from scratch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_a <= step_btn;
      btn_s  <= sync_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
            if (db_cnt == DB_PRE_LAST) begin
              state      <= PRESSED;
              step_pulse <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to PRESSED silently.
          if (btn_s) begin
            state <= PRESSED;
          end else begin
            db_cnt <= db_cnt + 1'b1;
            if (db_cnt == DB_PRE_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Snapshot only at the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt   <= '0;
      digit_idx <= 2'd0;
      snapshot  <= 16'h0;
    end else if (ref_cnt == RF_LAST) begin
      ref_cnt   <= '0;
      digit_idx <= digit_idx + 2'd1;
      if (digit_idx == 2'd3) begin
        snapshot <= pick_half(view_sel ? reg_in : pc_in, half_sel);
      end
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign nibble = snapshot[{digit_idx, 2'b00} +: 4];

  seg7_decoder u_dec (
    .hex (nibble),
    .seg (seg_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      anode <= AN_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else begin
      anode <= digit_anode(digit_idx);
      seg   <= seg_next;
      dp    <= ~((digit_idx == 2'd3) & half_sel);
    end
  end

endmodule
